// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync, data-enable, coordinates and
// frame/line strobes, with a mode-change handshake applied at frame wrap.
module video_timing_gen #(
  parameter int unsigned HW         = 13,
  parameter int unsigned VW         = 12,
  parameter int unsigned FW         = 16,
  parameter int unsigned H_ACTIVE   = 1920,
  parameter int unsigned H_SYNC_STA = 2008,
  parameter int unsigned H_SYNC_END = 2052,
  parameter int unsigned H_TOTAL    = 2200,
  parameter int unsigned V_ACTIVE   = 1080,
  parameter int unsigned V_SYNC_STA = 1084,
  parameter int unsigned V_SYNC_END = 1089,
  parameter int unsigned V_TOTAL    = 1125,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ce,
  input  logic          i_cfg_valid,
  output logic          o_cfg_ready,
  input  logic [HW-1:0] i_cfg_h_active,
  input  logic [HW-1:0] i_cfg_h_sync_sta,
  input  logic [HW-1:0] i_cfg_h_sync_end,
  input  logic [HW-1:0] i_cfg_h_total,
  input  logic [VW-1:0] i_cfg_v_active,
  input  logic [VW-1:0] i_cfg_v_sync_sta,
  input  logic [VW-1:0] i_cfg_v_sync_end,
  input  logic [VW-1:0] i_cfg_v_total,
  output logic          o_cfg_ack,
  output logic          o_cfg_err,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_de,
  output logic [HW-1:0] o_x,
  output logic [VW-1:0] o_y,
  output logic          o_line_start,
  output logic          o_frame_start,
  output logic          o_vblank_start,
  output logic [FW-1:0] o_frame
);

  typedef struct packed {
    logic [HW-1:0] h_active;
    logic [HW-1:0] h_sync_sta;
    logic [HW-1:0] h_sync_end;
    logic [HW-1:0] h_total;
    logic [VW-1:0] v_active;
    logic [VW-1:0] v_sync_sta;
    logic [VW-1:0] v_sync_end;
    logic [VW-1:0] v_total;
  } mode_t;

  localparam mode_t DEFAULT_MODE = '{
    h_active:   HW'(H_ACTIVE),
    h_sync_sta: HW'(H_SYNC_STA),
    h_sync_end: HW'(H_SYNC_END),
    h_total:    HW'(H_TOTAL),
    v_active:   VW'(V_ACTIVE),
    v_sync_sta: VW'(V_SYNC_STA),
    v_sync_end: VW'(V_SYNC_END),
    v_total:    VW'(V_TOTAL)
  };

  mode_t         mode_q, mode_d;
  mode_t         shadow_q, shadow_d;
  mode_t         cfg_in;
  logic          pending_q, pending_d;
  logic          applied_q, applied_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic [HW-1:0] x_q, x_d;
  logic [VW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          vblank_start_q, vblank_start_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;

  logic cfg_fire, cfg_legal;
  logic h_last, v_last, h_in_active, v_in_active, at_origin;

  assign cfg_in = '{
    h_active:   i_cfg_h_active,
    h_sync_sta: i_cfg_h_sync_sta,
    h_sync_end: i_cfg_h_sync_end,
    h_total:    i_cfg_h_total,
    v_active:   i_cfg_v_active,
    v_sync_sta: i_cfg_v_sync_sta,
    v_sync_end: i_cfg_v_sync_end,
    v_total:    i_cfg_v_total
  };

  // A legal mode also guarantees total-1 fits the counter width.
  assign cfg_legal = (cfg_in.h_active != '0)
                  && (cfg_in.h_active   <  cfg_in.h_sync_sta)
                  && (cfg_in.h_sync_sta <  cfg_in.h_sync_end)
                  && (cfg_in.h_sync_end <= cfg_in.h_total)
                  && (cfg_in.v_active != '0)
                  && (cfg_in.v_active   <  cfg_in.v_sync_sta)
                  && (cfg_in.v_sync_sta <  cfg_in.v_sync_end)
                  && (cfg_in.v_sync_end <= cfg_in.v_total);

  assign cfg_fire    = i_cfg_valid && !pending_q;
  assign h_last      = (h_q == mode_q.h_total - HW'(1));
  assign v_last      = (v_q == mode_q.v_total - VW'(1));
  assign h_in_active = (h_q < mode_q.h_active);
  assign v_in_active = (v_q < mode_q.v_active);
  assign at_origin   = (h_q == '0) && (v_q == '0);

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned
    // (which would infer a latch); strobes default low so they last one cycle.
    mode_d         = mode_q;
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    applied_d      = applied_q;
    h_d            = h_q;
    v_d            = v_q;
    hs_d           = hs_q;
    vs_d           = vs_q;
    de_d           = de_q;
    x_d            = x_q;
    y_d            = y_q;
    frame_d        = frame_q;
    line_start_d   = 1'b0;
    frame_start_d  = 1'b0;
    vblank_start_d = 1'b0;
    ack_d          = 1'b0;
    err_d          = 1'b0;

    if (i_ce) begin
      de_d           = h_in_active && v_in_active;
      x_d            = (h_in_active && v_in_active) ? h_q : '0;
      y_d            = v_in_active ? v_q : '0;
      hs_d           = ((h_q >= mode_q.h_sync_sta) && (h_q < mode_q.h_sync_end)) ? HS_POL : ~HS_POL;
      vs_d           = ((v_q >= mode_q.v_sync_sta) && (v_q < mode_q.v_sync_end)) ? VS_POL : ~VS_POL;
      line_start_d   = (h_q == '0);
      frame_start_d  = at_origin;
      vblank_start_d = (h_q == '0) && (v_q == mode_q.v_active);
      if (at_origin) frame_d = frame_q + FW'(1);
      // The ack is deferred to the first pixel of the frame the new mode drives.
      if (applied_q && at_origin) begin
        ack_d     = 1'b1;
        applied_d = 1'b0;
      end

      if (h_last) begin
        h_d = '0;
        if (v_last) begin
          v_d = '0;
          if (pending_q) begin
            mode_d    = shadow_q;
            pending_d = 1'b0;
            applied_d = 1'b1;
          end
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end

    // Uses the pre-edge pending flag, so a transfer on a wrap cycle waits a frame.
    if (cfg_fire) begin
      if (cfg_legal) begin
        shadow_d  = cfg_in;
        pending_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mode_q         <= DEFAULT_MODE;
      shadow_q       <= DEFAULT_MODE;
      pending_q      <= 1'b0;
      applied_q      <= 1'b0;
      h_q            <= '0;
      v_q            <= '0;
      hs_q           <= ~HS_POL;
      vs_q           <= ~VS_POL;
      de_q           <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      frame_q        <= '0;
      ack_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      applied_q      <= applied_d;
      h_q            <= h_d;
      v_q            <= v_d;
      hs_q           <= hs_d;
      vs_q           <= vs_d;
      de_q           <= de_d;
      x_q            <= x_d;
      y_q            <= y_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      vblank_start_q <= vblank_start_d;
      frame_q        <= frame_d;
      ack_q          <= ack_d;
      err_q          <= err_d;
    end
  end

  assign o_cfg_ready    = !pending_q;
  assign o_cfg_ack      = ack_q;
  assign o_cfg_err      = err_q;
  assign o_hs           = hs_q;
  assign o_vs           = vs_q;
  assign o_de           = de_q;
  assign o_x            = x_q;
  assign o_y            = y_q;
  assign o_line_start   = line_start_q;
  assign o_frame_start  = frame_start_q;
  assign o_vblank_start = vblank_start_q;
  assign o_frame        = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a small-mode instance (active-low syncs) checked
// through an expected-output queue, plus a default-parameter 1080p instance.
module tb_video_timing_gen;

  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b0;

  typedef struct {
    int ha, hss, hse, ht;
    int va, vss, vse, vt;
  } tb_mode_t;

  typedef struct packed {
    logic        hs, vs, de;
    logic [12:0] x;
    logic [11:0] y;
    logic        ls, fs, vb;
    logic [15:0] frame;
    logic        ack, err, ready;
  } out_t;

  localparam tb_mode_t MODE_S = '{8, 10, 12, 14, 4, 5, 6, 8};
  localparam tb_mode_t MODE_B = '{4, 5, 6, 7, 2, 3, 4, 5};
  localparam tb_mode_t MODE_X = '{4, 3, 6, 7, 2, 3, 4, 5};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready, cfg_ack, cfg_err;
  logic [12:0] cfg_h_active = '0, cfg_h_sync_sta = '0, cfg_h_sync_end = '0, cfg_h_total = '0;
  logic [11:0] cfg_v_active = '0, cfg_v_sync_sta = '0, cfg_v_sync_end = '0, cfg_v_total = '0;
  logic        o_hs, o_vs, o_de, o_line_start, o_frame_start, o_vblank_start;
  logic [12:0] o_x;
  logic [11:0] o_y;
  logic [15:0] o_frame;

  logic        hd_ce = 1'b0;
  logic        hd_ready, hd_ack, hd_err, hd_hs, hd_vs, hd_de, hd_ls, hd_fs, hd_vb;
  logic [12:0] hd_x;
  logic [11:0] hd_y;
  logic [15:0] hd_frame;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_SYNC_STA(10), .H_SYNC_END(12), .H_TOTAL(14),
    .V_ACTIVE(4), .V_SYNC_STA(5),  .V_SYNC_END(6),  .V_TOTAL(8),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_h_active(cfg_h_active), .i_cfg_h_sync_sta(cfg_h_sync_sta),
    .i_cfg_h_sync_end(cfg_h_sync_end), .i_cfg_h_total(cfg_h_total),
    .i_cfg_v_active(cfg_v_active), .i_cfg_v_sync_sta(cfg_v_sync_sta),
    .i_cfg_v_sync_end(cfg_v_sync_end), .i_cfg_v_total(cfg_v_total),
    .o_cfg_ack(cfg_ack), .o_cfg_err(cfg_err),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_x(o_x), .o_y(o_y),
    .o_line_start(o_line_start), .o_frame_start(o_frame_start),
    .o_vblank_start(o_vblank_start), .o_frame(o_frame)
  );

  video_timing_gen u_hd (
    .i_clk(clk), .i_rst(rst), .i_ce(hd_ce),
    .i_cfg_valid(1'b0), .o_cfg_ready(hd_ready),
    .i_cfg_h_active(13'd0), .i_cfg_h_sync_sta(13'd0),
    .i_cfg_h_sync_end(13'd0), .i_cfg_h_total(13'd0),
    .i_cfg_v_active(12'd0), .i_cfg_v_sync_sta(12'd0),
    .i_cfg_v_sync_end(12'd0), .i_cfg_v_total(12'd0),
    .o_cfg_ack(hd_ack), .o_cfg_err(hd_err),
    .o_hs(hd_hs), .o_vs(hd_vs), .o_de(hd_de), .o_x(hd_x), .o_y(hd_y),
    .o_line_start(hd_ls), .o_frame_start(hd_fs),
    .o_vblank_start(hd_vb), .o_frame(hd_frame)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  out_t exp_q[$];

  // Expected-behaviour state: linear position in the frame plus handshake flags.
  tb_mode_t cur, shadow;
  int   m_p;
  bit   m_pend, m_applied;
  out_t last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit legal(input tb_mode_t c);
    return c.ha > 0 && c.ha < c.hss && c.hss < c.hse && c.hse <= c.ht &&
           c.va > 0 && c.va < c.vss && c.vss < c.vse && c.vse <= c.vt;
  endfunction

  function automatic out_t get_out();
    out_t a;
    a.hs = o_hs; a.vs = o_vs; a.de = o_de; a.x = o_x; a.y = o_y;
    a.ls = o_line_start; a.fs = o_frame_start; a.vb = o_vblank_start;
    a.frame = o_frame; a.ack = cfg_ack; a.err = cfg_err; a.ready = cfg_ready;
    return a;
  endfunction

  function automatic void model_reset();
    cur = MODE_S; shadow = MODE_S;
    m_p = 0; m_pend = 1'b0; m_applied = 1'b0;
    last = '0;
    last.hs = ~HSP; last.vs = ~VSP; last.ready = 1'b1;
    exp_q.delete();
  endfunction

  task automatic tick_cfg(input bit ce_v, input bit vld, input tb_mode_t c);
    out_t e;
    int h, v;
    bit fire;
    @(negedge clk);
    ce = ce_v; cfg_valid = vld;
    cfg_h_active = 13'(c.ha); cfg_h_sync_sta = 13'(c.hss);
    cfg_h_sync_end = 13'(c.hse); cfg_h_total = 13'(c.ht);
    cfg_v_active = 12'(c.va); cfg_v_sync_sta = 12'(c.vss);
    cfg_v_sync_end = 12'(c.vse); cfg_v_total = 12'(c.vt);
    e = last;
    e.ls = 1'b0; e.fs = 1'b0; e.vb = 1'b0; e.ack = 1'b0; e.err = 1'b0;
    fire = vld && !m_pend;
    if (ce_v) begin
      h = m_p % cur.ht;
      v = m_p / cur.ht;
      e.de = (h < cur.ha) && (v < cur.va);
      e.x  = e.de ? 13'(h) : 13'd0;
      e.y  = (v < cur.va) ? 12'(v) : 12'd0;
      e.hs = (h >= cur.hss && h < cur.hse) ? HSP : ~HSP;
      e.vs = (v >= cur.vss && v < cur.vse) ? VSP : ~VSP;
      e.ls = (h == 0);
      e.fs = (m_p == 0);
      e.vb = (h == 0) && (v == cur.va);
      if (m_p == 0) e.frame = e.frame + 16'd1;
      if (m_applied && m_p == 0) begin
        e.ack = 1'b1;
        m_applied = 1'b0;
      end
      m_p++;
      if (m_p == cur.ht * cur.vt) begin
        m_p = 0;
        if (m_pend) begin
          cur = shadow; m_pend = 1'b0; m_applied = 1'b1;
        end
      end
    end
    if (fire) begin
      if (legal(c)) begin
        shadow = c; m_pend = 1'b1;
      end else begin
        e.err = 1'b1;
      end
    end
    e.ready = !m_pend;
    last = e;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
    ce = 1'b0; cfg_valid = 1'b0;
  endtask

  task automatic tick(input bit ce_v);
    tick_cfg(ce_v, 1'b0, MODE_S);
  endtask

  // Ticks with ce=1 until a frame-start output appears; n is the tick count.
  task automatic ticks_to_fs(output int n);
    n = 0;
    do begin
      tick(1'b1);
      n++;
    end while (!o_frame_start && n < 400);
  endtask

  // Monitor: compares each presented output cycle with the queued expectation.
  initial begin
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("out_c%0d", cyc), 64'(get_out()), 64'(e));
      end
    end
  end

  initial begin
    int n, cnt_de, cnt_hs, cnt_vs, strobe_on_idle;
    int fs_idx[$];
    int ls_idx[$];

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_hs_idle", o_hs, 1'b1);
    check("rst_vs_idle", o_vs, 1'b1);
    check("rst_de", o_de, 1'b0);
    check("rst_frame", o_frame, 16'd0);
    check("rst_ready", cfg_ready, 1'b1);
    check("rst_strobes", {o_line_start, o_frame_start, o_vblank_start, cfg_ack}, 4'b0);
    @(negedge clk);
    rst = 1'b1;

    // First ce cycle presents (0,0) with both start strobes and frame 1.
    tick(1'b1);
    check("first_xy", {o_x, o_y}, 25'd0);
    check("first_de", o_de, 1'b1);
    check("first_strobes", {o_line_start, o_frame_start}, 2'b11);
    check("first_frame", o_frame, 16'd1);
    cnt_de = 1; cnt_hs = 0; cnt_vs = 0;
    fs_idx.delete(); fs_idx.push_back(0);
    for (int i = 1; i < 336; i++) begin
      tick(1'b1);
      if (o_de) cnt_de++;
      if (!o_hs) cnt_hs++;
      if (!o_vs) cnt_vs++;
      if (o_frame_start) fs_idx.push_back(i);
    end
    check("de_count_3fr", cnt_de, 96);
    check("hs_low_count_3fr", cnt_hs, 48);
    check("vs_low_count_3fr", cnt_vs, 42);
    check("fs_count_3fr", fs_idx.size(), 3);
    check("fs_period", (fs_idx.size() > 1) ? fs_idx[1] : -1, 112);
    check("frame_after_3", o_frame, 16'd3);

    // Alternating clock-enable doubles the frame period in clocks.
    fs_idx.delete(); strobe_on_idle = 0;
    for (int i = 0; i < 226; i++) begin
      tick(i % 2 == 0);
      if (o_frame_start) fs_idx.push_back(i);
      if (i % 2 == 1 && (o_line_start || o_frame_start || o_vblank_start || cfg_ack))
        strobe_on_idle++;
    end
    check("ce_fs_count", fs_idx.size(), 2);
    check("ce_fs_period", (fs_idx.size() > 1) ? fs_idx[1] : -1, 224);
    check("ce_idle_strobes", strobe_on_idle, 0);
    check("ce_frame", o_frame, 16'd5);

    // Mode change offered at line 1: old frame finishes, then a 35-cycle frame.
    while (m_p != 14) tick(1'b1);
    tick_cfg(1'b1, 1'b1, MODE_B);
    check("pend_ready_low", cfg_ready, 1'b0);
    ticks_to_fs(n);
    check("old_frame_rest", n, 98);
    check("ack_at_fs", {cfg_ack, o_frame_start}, 2'b11);
    check("ready_after_apply", cfg_ready, 1'b1);
    ticks_to_fs(n);
    check("new_frame_len", n, 35);
    check("frame_after_change", o_frame, 16'd7);

    // Illegal mode: error pulse, ready stays high, timing unchanged.
    tick_cfg(1'b1, 1'b1, MODE_X);
    check("illegal_err", cfg_err, 1'b1);
    check("illegal_ready", cfg_ready, 1'b1);
    ticks_to_fs(n);
    check("illegal_keeps_mode", n, 34);

    // Transfer on the wrap cycle takes effect one frame later.
    while (m_p != 34) tick(1'b1);
    tick_cfg(1'b1, 1'b1, MODE_S);
    check("wrap_xfer_ready", cfg_ready, 1'b0);
    ticks_to_fs(n);
    check("wrap_no_ack", {n[7:0], cfg_ack}, {8'd1, 1'b0});
    ticks_to_fs(n);
    check("wrap_next_len", n, 35);
    check("wrap_ack", cfg_ack, 1'b1);
    ticks_to_fs(n);
    check("wrap_applied_len", n, 112);

    // Reset mid-frame with a pending mode discards it.
    repeat (20) tick(1'b1);
    tick_cfg(1'b1, 1'b1, MODE_B);
    check("pre_rst_pending", cfg_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_async_outs", {o_hs, o_vs, o_de, o_x, o_y}, {1'b1, 1'b1, 1'b0, 25'd0});
    check("rst_async_frame", o_frame, 16'd0);
    check("rst_async_ready", cfg_ready, 1'b1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    ticks_to_fs(n);
    check("post_rst_first_fs", {n[7:0], o_frame}, {8'd1, 16'd1});
    ticks_to_fs(n);
    check("post_rst_default_len", n, 112);

    // Default 1080p instance: two full lines.
    @(negedge clk);
    hd_ce = 1'b1;
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; ls_idx.delete();
    for (int i = 0; i < 4400; i++) begin
      @(posedge clk);
      #2;
      if (i == 0) check("hd_first", {hd_fs, hd_de, hd_x, hd_frame}, {1'b1, 1'b1, 13'd0, 16'd1});
      if (hd_de) cnt_de++;
      if (hd_hs) cnt_hs++;
      if (hd_vs || hd_vb) cnt_vs++;
      if (hd_ls) ls_idx.push_back(i);
      if (i == 2200) check("hd_line1_y", {hd_y, hd_x}, {12'd1, 13'd0});
    end
    hd_ce = 1'b0;
    check("hd_de_count", cnt_de, 3840);
    check("hd_hs_count", cnt_hs, 88);
    check("hd_vs_vb_quiet", cnt_vs, 0);
    check("hd_line_count", ls_idx.size(), 2);
    check("hd_line_period", (ls_idx.size() > 1) ? ls_idx[1] : -1, 2200);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
